// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table capture sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  localparam int unsigned NUM_VEC    = 16;
  localparam int unsigned VEC_W      = 4;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 7;
  localparam int unsigned CNT_W      = 3;

endpackage

// File: rtl/truth_table_capture.sv
// Sweeps all 16 input vectors of a 4-input function, holds each for SETTLE
// cycles, captures the response mask and compares it against a golden mask.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_VEC-1:0] expected,
  output logic [VEC_W-1:0]   vec_out,
  input  logic               f_in,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] mask,
  output logic               pass,
  output logic [4:0]         mismatch_cnt,
  output logic [VEC_W-1:0]   first_err,
  output logic               err_valid
);

  // Out-of-range SETTLE is clamped so the counter compare stays well defined.
  localparam int unsigned SETTLE_C = (SETTLE < SETTLE_MIN) ? SETTLE_MIN :
                                     (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_C - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [4:0]       MAX_MIS  = 5'(NUM_VEC);

  tt_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [VEC_W-1:0]   r_vec;
  logic [NUM_VEC-1:0] r_exp;
  logic [NUM_VEC-1:0] r_mask;
  logic [4:0]         r_mcnt;
  logic [VEC_W-1:0]   r_first;
  logic               r_errv;
  logic               r_pass;

  logic w_accept;
  logic w_sample;
  logic w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // abort outranks the sample that would otherwise land this edge
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_sample = 1'b1;
          if (r_vec == LAST_VEC) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_mis = w_sample && (f_in != r_exp[r_vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_vec   <= '0;
      r_exp   <= '0;
      r_mask  <= '0;
      r_mcnt  <= '0;
      r_first <= '0;
      r_errv  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (w_accept) begin
      r_exp   <= expected;
      r_mask  <= '0;
      r_mcnt  <= '0;
      r_first <= '0;
      r_errv  <= 1'b0;
      r_pass  <= 1'b0;
      r_vec   <= '0;
      r_cnt   <= '0;
    end else if (r_state == WAIT) begin
      if (abort) begin
        r_vec  <= '0;
        r_cnt  <= '0;
        r_pass <= 1'b0;
      end else if (w_sample) begin
        r_mask[r_vec] <= f_in;
        r_cnt         <= '0;
        if (w_mis) begin
          if (r_mcnt != MAX_MIS) r_mcnt <= r_mcnt + 5'd1;
          if (!r_errv) begin
            r_first <= r_vec;
            r_errv  <= 1'b1;
          end
        end
        if (r_vec == LAST_VEC) begin
          r_vec  <= '0;
          r_pass <= (r_mcnt == '0) && !w_mis;
        end else begin
          r_vec <= r_vec + 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign vec_out      = r_vec;
  assign busy         = (r_state == WAIT);
  assign done         = (r_state == DONE);
  assign mask         = r_mask;
  assign pass         = r_pass;
  assign mismatch_cnt = r_mcnt;
  assign first_err    = r_first;
  assign err_valid    = r_errv;

endmodule

// File: tb/tb_truth_table_capture.sv
// Randomized bench for truth_table_capture: two instances (SETTLE=1 and 3)
// checked against a mask-level reference model.
module tb_truth_table_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a    [2];
  logic        abort_a    [2];
  logic [15:0] exp_a      [2];
  logic [15:0] fn_a       [2];
  logic [3:0]  vec_a      [2];
  logic        f_in_a     [2];
  logic        busy_a     [2];
  logic        done_a     [2];
  logic [15:0] mask_a     [2];
  logic        pass_a     [2];
  logic [4:0]  mcnt_a     [2];
  logic [3:0]  first_a    [2];
  logic        errv_a     [2];

  int checks   = 0;
  int failures = 0;
  int settle_of [2] = '{1, 3};

  always #5 clk = ~clk;

  assign f_in_a[0] = fn_a[0][vec_a[0]];
  assign f_in_a[1] = fn_a[1][vec_a[1]];

  truth_table_capture #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .abort(abort_a[0]),
    .expected(exp_a[0]), .vec_out(vec_a[0]), .f_in(f_in_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .mask(mask_a[0]), .pass(pass_a[0]),
    .mismatch_cnt(mcnt_a[0]), .first_err(first_a[0]), .err_valid(errv_a[0])
  );

  truth_table_capture #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .abort(abort_a[1]),
    .expected(exp_a[1]), .vec_out(vec_a[1]), .f_in(f_in_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .mask(mask_a[1]), .pass(pass_a[1]),
    .mismatch_cnt(mcnt_a[1]), .first_err(first_a[1]), .err_valid(errv_a[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // A(CD+B) + B~C evaluated per vector index
  function automatic logic [15:0] ref_fn();
    logic [15:0] t;
    t = '0;
    for (int n = 0; n < 16; n++) begin
      int a, b, c, d;
      a = (n >> 3) & 1; b = (n >> 2) & 1; c = (n >> 1) & 1; d = n & 1;
      t[n] = ((a & ((c & d) | b)) | (b & (1 - c))) != 0;
    end
    return t;
  endfunction

  function automatic int count_ones(input logic [15:0] v);
    int k = 0;
    for (int n = 0; n < 16; n++) if (v[n]) k++;
    return k;
  endfunction

  function automatic int lowest_one(input logic [15:0] v);
    for (int n = 0; n < 16; n++) if (v[n]) return n;
    return 0;
  endfunction

  task automatic check_results(input int d, input string pfx, input logic [15:0] m,
                               input logic [15:0] diff, input logic want_pass);
    int mis;
    mis = count_ones(diff);
    check_eq({pfx, "_mask"},  mask_a[d],  m);
    check_eq({pfx, "_mcnt"},  mcnt_a[d],  mis);
    check_eq({pfx, "_first"}, first_a[d], lowest_one(diff));
    check_eq({pfx, "_errv"},  errv_a[d],  mis != 0);
    check_eq({pfx, "_pass"},  pass_a[d],  want_pass);
  endtask

  task automatic sweep(input int d, input logic [15:0] fn, input logic [15:0] ex,
                       input bit poke_start);
    int s, j, bad, highs;
    bit seen;
    s = settle_of[d];
    fn_a[d]  = fn;
    exp_a[d] = ex;
    @(negedge clk) start_a[d] = 1'b1;
    @(negedge clk) start_a[d] = 1'b0;
    j = 0; bad = 0; seen = 0;
    while (j < 16 * s + 50 && !seen) begin
      if (done_a[d]) begin
        seen = 1;
      end else begin
        if (vec_a[d] != 4'(j / s)) bad++;
        if (!busy_a[d]) bad++;
        start_a[d] = (poke_start && j < 16 * s - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        j++;
      end
    end
    start_a[d] = 1'b0;
    check_eq($sformatf("latency_s%0d", s), seen ? j : -1, 16 * s);
    check_eq($sformatf("hold_s%0d", s), bad, 0);
    check_eq("done_vec", vec_a[d], 0);
    check_eq("done_busy", busy_a[d], 0);
    check_results(d, "sweep", fn, fn ^ ex, fn == ex);
    highs = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_a[d] || busy_a[d]) highs++;
    end
    check_eq("single_done", highs, 0);
    check_results(d, "held", fn, fn ^ ex, fn == ex);
  endtask

  task automatic abort_at7(input int d, input logic [15:0] fn, input logic [15:0] ex);
    int j, dn;
    fn_a[d]  = fn;
    exp_a[d] = ex;
    @(negedge clk) start_a[d] = 1'b1;
    @(negedge clk) start_a[d] = 1'b0;
    j = 0;
    while (vec_a[d] != 4'd7 && j < 200) begin
      @(negedge clk);
      j++;
    end
    check_eq("abort_reach7", vec_a[d], 7);
    abort_a[d] = 1'b1;
    @(negedge clk) abort_a[d] = 1'b0;
    check_eq("abort_busy", busy_a[d], 0);
    check_eq("abort_vec", vec_a[d], 0);
    check_eq("abort_done", done_a[d], 0);
    check_results(d, "abort", fn & 16'h007F, (fn ^ ex) & 16'h007F, 1'b0);
    dn = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_a[d]) dn++;
    end
    check_eq("abort_nodone", dn, 0);
  endtask

  task automatic check_all_zero(input int d, input string pfx);
    check_eq({pfx, "_vec"},   vec_a[d],   0);
    check_eq({pfx, "_busy"},  busy_a[d],  0);
    check_eq({pfx, "_done"},  done_a[d],  0);
    check_eq({pfx, "_mask"},  mask_a[d],  0);
    check_eq({pfx, "_pass"},  pass_a[d],  0);
    check_eq({pfx, "_mcnt"},  mcnt_a[d],  0);
    check_eq({pfx, "_first"}, first_a[d], 0);
    check_eq({pfx, "_errv"},  errv_a[d],  0);
  endtask

  initial begin
    logic [15:0] fr, rf, re;
    int j;
    for (int d = 0; d < 2; d++) begin
      start_a[d] = 1'b0; abort_a[d] = 1'b0; exp_a[d] = '0; fn_a[d] = '0;
    end
    fr = ref_fn();
    #23;
    check_all_zero(0, "rst1");
    check_all_zero(1, "rst3");
    @(negedge clk) rst_n = 1'b1;

    sweep(0, fr, 16'hF830, 1'b0);
    sweep(0, fr, 16'hF831, 1'b0);
    sweep(0, 16'hFFFF, 16'h0000, 1'b0);
    sweep(1, fr, 16'hF830, 1'b1);
    sweep(1, fr, 16'hF831, 1'b1);

    abort_at7(0, fr, 16'hF830);
    abort_at7(1, 16'hFFFF, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      rf = 16'($urandom);
      re = ($urandom_range(0, 2) == 0) ? rf : (rf ^ (16'($urandom) & 16'($urandom)));
      sweep(i % 2, rf, re, i % 2 == 1);
    end

    // reset while the SETTLE=1 instance is on vector 9
    fn_a[0] = fr; exp_a[0] = 16'hF830;
    @(negedge clk) start_a[0] = 1'b1;
    @(negedge clk) start_a[0] = 1'b0;
    j = 0;
    while (vec_a[0] != 4'd9 && j < 200) begin
      @(negedge clk);
      j++;
    end
    check_eq("rstmid_reach9", vec_a[0], 9);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero(0, "rstmid");
    repeat (3) @(negedge clk);
    check_eq("rstmid_hold_done", done_a[0], 0);
    rst_n = 1'b1;
    sweep(0, fr, 16'hF830, 1'b0);
    sweep(1, fr, 16'hF830, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
